// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave core.
package i2c_slave_pkg;

  localparam logic [6:0]  DEFAULT_SLAVE_ADDR = 7'b1010101;
  // Shortest SCL high/low phase, in core clocks, that the slave is built to follow.
  localparam int unsigned MIN_PHASE_CLKS     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers, SCL edge detection and START/STOP detection.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_c,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_s, sda_s;

  always_comb begin
    scl_sync_d = SYNC_STAGES'({scl_sync_q, scl_i});
    sda_sync_d = SYNC_STAGES'({sda_sync_q, sda_i});
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    sda_c      = sda_s;
    scl_rise_c = scl_s & ~scl_prev_q;
    scl_fall_c = ~scl_s & scl_prev_q;
    // SDA may only change while SCL is high for START/STOP conditions.
    start_c    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    stop_c     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

endmodule

// File: rtl/i2c_slave_core.sv
// 7-bit addressed I2C slave: byte write sink and byte read source with open-drain SDA.
module i2c_slave_core
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i2c_core_clock_i,
  input  logic       preset_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_req_o,
  output logic       rw_o,
  output logic       busy_o,
  output logic       start_det_o,
  output logic       stop_det_o
);

  logic sda_c, scl_rise_c, scl_fall_c, start_c, stop_c;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk       (i2c_core_clock_i),
    .rst_n     (preset_n_i),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_c     (sda_c),
    .scl_rise_c(scl_rise_c),
    .scl_fall_c(scl_fall_c),
    .start_c   (start_c),
    .stop_c    (stop_c)
  );

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       phase_q, phase_d;
  logic       ack_ok_q, ack_ok_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    phase_d     = phase_q;
    ack_ok_d    = ack_ok_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    start_det_d = start_c;
    stop_det_d  = stop_c;

    if (stop_c) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      phase_d   = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (start_c) begin
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      phase_d   = 1'b0;
      bit_cnt_d = 3'd0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise_c) begin
            shift_d   = {shift_q[6:0], sda_c};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_d[7:1] == SLAVE_ADDR) begin
                state_d  = ST_ADDR_ACK;
                rw_d     = shift_d[0];
                busy_d   = 1'b1;
                tx_req_d = shift_d[0];
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        // phase_q marks that the ACK bit is being driven; its end falls on the next SCL fall.
        ST_ADDR_ACK: begin
          if (scl_fall_c) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              if (rw_q) begin
                shift_d  = tx_data_i;
                sda_oe_d = ~tx_data_i[7];
                state_d  = ST_RD_DATA;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_WR_DATA;
              end
            end
          end
        end
        ST_WR_DATA: begin
          if (scl_rise_c) begin
            shift_d   = {shift_q[6:0], sda_c};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = shift_d;
              rx_valid_d = rx_ready_i;
              ack_ok_d   = rx_ready_i;
              state_d    = ST_WR_ACK;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall_c) begin
            if (!phase_q) begin
              sda_oe_d = ack_ok_q;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = ST_WR_DATA;
            end
          end
        end
        ST_RD_DATA: begin
          if (scl_fall_c) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = ST_RD_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise_c) begin
            if (!sda_c) begin
              tx_req_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (scl_fall_c) begin
            shift_d   = tx_data_i;
            sda_oe_d  = ~tx_data_i[7];
            bit_cnt_d = 3'd0;
            state_d   = ST_RD_DATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i2c_core_clock_i) begin
    if (!preset_n_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      phase_q     <= 1'b0;
      ack_ok_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      ack_ok_q    <= ack_ok_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  assign sda_oe_o    = sda_oe_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign tx_req_o    = tx_req_q;
  assign rw_o        = rw_q;
  assign busy_o      = busy_q;
  assign start_det_o = start_det_q;
  assign stop_det_o  = stop_det_q;

endmodule

// File: doc/i2c_slave_core.md
I2C_SLAVE_CORE -- requirements
Module: i2c_slave_core

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b1010101, the 7-bit address this slave answers.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of SCL/SDA input synchroniser flops.
REQ-003 SHALL have port i2c_core_clock_i  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port preset_n_i  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port scl_i  input  1  SCL bus level, asynchronous to the clock.
REQ-006 SHALL have port sda_i  input  1  SDA bus level, asynchronous to the clock.
REQ-007 SHALL have port sda_oe_o  output  1  open-drain pull-down enable (1 = drive SDA low, 0 = release).
REQ-008 SHALL have port rx_data_o  output  8  last received write-data byte.
REQ-009 SHALL have port rx_valid_o  output  1  one-cycle pulse when rx_data_o updates.
REQ-010 SHALL have port rx_ready_i  input  1  sink can take a byte; 0 makes the slave NACK the byte.
REQ-011 SHALL have port tx_data_i  input  8  byte to transmit on a read.
REQ-012 SHALL have port tx_req_o  output  1  one-cycle pulse requesting the next tx_data_i.
REQ-013 SHALL have port rw_o  output  1  R/W bit of the last matched address byte.
REQ-014 SHALL have port busy_o  output  1  high from a matched address ACK until the next STOP or START.
REQ-015 SHALL have ports start_det_o and stop_det_o  output  1 each  one-cycle pulses on START/repeated START and on STOP.

Function
REQ-016 SHALL synchronise scl_i and sda_i through SYNC_STAGES flops, then edge-detect them; pin-to-action latency is SYNC_STAGES+1 clocks.
REQ-017 SHALL require SCL high and low phases of at least 4 clocks each; shorter phases are out of contract.
REQ-018 SHALL detect START as synced SDA falling while synced SCL is high, and STOP as synced SDA rising while synced SCL is high.
REQ-019 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-020 SHALL, on START in any state, go to ADDR, clear the bit counter, release sda_oe_o and drop busy_o.
REQ-021 SHALL, on STOP in any state, go to IDLE and release sda_oe_o; STOP takes priority over any coincident SCL edge.
REQ-022 SHALL sample SDA MSB-first on each SCL rising edge in ADDR and WR_DATA, using a 3-bit counter that wraps after 8 bits.
REQ-023 SHALL, on the 8th address bit: if byte[7:1]==SLAVE_ADDR, latch rw_o = byte[0] and enter ADDR_ACK; otherwise go to IDLE without driving SDA.
REQ-024 SHALL pulse tx_req_o in the cycle ADDR_ACK is entered with rw_o=1.
REQ-025 SHALL, in ADDR_ACK and WR_ACK, assert sda_oe_o on the next SCL falling edge (for an ACK) and release it on the following SCL falling edge.
REQ-026 SHALL assert busy_o at ADDR_ACK entry.
REQ-027 SHALL, at the ADDR_ACK-ending falling edge, go to WR_DATA when rw_o=0; when rw_o=1, load tx_data_i into the shift register, drive its MSB (sda_oe_o = ~bit) and go to RD_DATA.
REQ-028 SHALL, on the 8th WR_DATA bit, update rx_data_o, pulse rx_valid_o only if rx_ready_i=1, and enter WR_ACK.
REQ-029 SHALL, in WR_ACK, ACK if rx_ready_i was 1 at the 8th bit and otherwise NACK (SDA released), then return to WR_DATA in both cases.
REQ-030 SHALL, in RD_DATA, shift out the next bit on each SCL falling edge, and release SDA at the falling edge after bit 8, entering RD_ACK.
REQ-031 SHALL, in RD_ACK, sample SDA on the SCL rising edge: on ACK (0), pulse tx_req_o; on NACK (1), go to IDLE.
REQ-032 SHALL, on the SCL falling edge that ends RD_ACK after an ACK, load tx_data_i and return to RD_DATA.
REQ-033 SHALL never drive SDA while in IDLE or ADDR.

Reset
REQ-034 SHALL, while preset_n_i=0 at a clock edge, enter IDLE with sda_oe_o=0, rx_data_o=0, rx_valid_o=0, tx_req_o=0, rw_o=0, busy_o=0, start/stop pulses 0, counters 0 and synchronisers at 1.
REQ-035 SHALL, on a reset asserted mid-transfer, release SDA in the cycle after the reset edge and ignore bus activity until the next START.

Structure
REQ-036 SHALL place the state enum, the default SLAVE_ADDR and the minimum phase constant in package i2c_slave_pkg.
REQ-037 SHALL contain one sub-module, i2c_bus_sync, which holds the synchronisers, edge detectors and START/STOP detector.

Verification
REQ-038 SHALL cover: write, START, 0xAA, 0xAA, 0x55, STOP -> ACK on all three bytes, rx_data_o 0xAA then 0x55 with one rx_valid_o each, rw_o=0.
REQ-039 SHALL cover: read, START, 0xAB, tx_data_i=0x3C, master ACK, then 0xC3, master NACK, STOP -> bus carries 0x3C then 0xC3, tx_req_o pulses 2x, state IDLE.
REQ-040 SHALL cover: address mismatch, START, 0xA8 -> sda_oe_o stays 0 throughout and busy_o stays 0.
REQ-041 SHALL cover: repeated START, write 0xAA, data 0x11, repeated START, 0xAB -> start_det_o pulses 2x and rw_o switches to 1 with no STOP.
REQ-042 SHALL cover: rx_ready_i=0 during byte 0x77 -> NACK on the 9th clock and no rx_valid_o pulse.
REQ-043 SHALL cover: preset_n_i low during the 4th RD_DATA bit -> sda_oe_o=0 one clock later and all outputs at reset values.
